tdm_demux4: RTL and testbench
=============================

Name: tdm_demux4

Overview:
- Receive-side counterpart of the team's 4:1 mux when it is used as a time-division multiplexer.
- Takes a serial stream of 1-bit samples, one per channel slot, with a frame-sync marker on slot 0.
- Steers each sample back to its channel and presents a complete 4-bit frame on a parallel output.
- Tracks frame alignment with a hunt/locked state machine, flywheels over missed syncs and reports misplaced syncs.

Parameters:
- MISS_MAX, default 2: consecutive slot-0 samples without sync tolerated before lock is dropped. Legal range 1..7.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- d  input  1  serial sample, qualified by en.
- sync  input  1  frame marker; high when the current en-qualified sample is slot 0. Ignored when en=0.
- en  input  1  sample strobe; one slot is consumed per clk edge with en=1.
- y  output  4  last complete frame; y[k] is the slot-k sample.
- valid  output  1  one-cycle pulse; y was updated at this edge.
- s  output  2  slot index expected for the next en sample.
- lock  output  1  high while in LOCKED.
- err  output  1  one-cycle pulse for a misplaced sync.

Behaviour:
- Reset (rst=1 at an edge, overrides every other input): y=0, valid=0, lock=0, err=0, s=0, state=HUNT, shadow sh[3:0]=0, miss counter=0. Reset mid-frame discards the partial frame.
- valid and err default to 0 every edge; they are high only for the single cycle after the causing edge.
- HUNT, en=1 and sync=1:
  - sh[0]<=d, s<=1, state<=LOCKED, lock<=1, miss<=0.
- HUNT, any other input:
  - No state change; d is discarded.
- LOCKED, en=0:
  - Everything holds.
- LOCKED, en=1, the accepted slot k is one of:
  - k=0 if sync=1.
  - Otherwise k=s.
- LOCKED, sync=1 and s=0:
  - Normal frame start; miss<=0.
- LOCKED, sync=1 and s≠0:
  - Misplaced sync: err<=1 and the sample is taken as slot 0.
  - Realign: s<=1, miss<=0.
  - The partial frame is abandoned; y is not updated for it.
- LOCKED, sync=0 and s=0 (missed sync):
  - miss<=miss+1.
  - If miss+1 < MISS_MAX: flywheel, the sample is accepted as slot 0.
  - If miss+1 = MISS_MAX: sample discarded, state<=HUNT, lock<=0, s<=0, miss<=0; y holds.
- Accepted sample, slot k:
  - sh[k]<=d, and s<=k+1 mod 4 (wraps 3->0).
  - If k=3: y<={d, sh[2:0]} and valid<=1 at the same edge. Latency is one clk from the slot-3 sample edge to y/valid visible.
- Only slot 3 writes y, and slots 1..2 are always rewritten after any realign. This guarantees y only ever holds a complete, aligned frame.
- sync on slots 1..3 with en=0 has no effect.
- Width rules: s is 2-bit and wraps naturally; the miss counter is 3 bits wide.

Test Plan:
- Reset, then frame en=1 every cycle, sync on the first sample, d=1,0,1,1:
  - lock=1 after the first edge; s steps 1,2,3,0.
  - After the 4th edge: y=4'b1101 and valid=1 for exactly one cycle.
- Two back-to-back frames, d=0,1,1,0 then 1,1,1,1:
  - y=4'b0110, then y=4'b1111.
  - valid pulses exactly 4 edges apart; no err.
- Same frame with en toggling 1,0,1,0,...:
  - Same y=4'b1101; valid arrives 7 cycles after the first sample.
  - s holds during en=0 cycles.
- Locked, sync asserted on slot 2, then a full frame d=0,0,0,1:
  - err=1 for one cycle; no valid for the broken frame.
  - Next valid gives y=4'b1000.
- MISS_MAX=2, locked, one frame start without sync:
  - Frame still completes with valid=1 and lock=1.
  - Second consecutive missing sync: lock=0, s=0, y unchanged.
  - Later en samples without sync are ignored until a sync relocks.
- Assert rst at slot 2 of a frame:
  - Next cycle: y=0, valid=0, lock=0, s=0.
  - Samples with sync=0 produce nothing until a sync is seen.

Source files
------------

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - TDM receive demux: 1-bit serial slots to aligned 4-bit frames
// Hunt/locked framing with flywheel over missed syncs and misplaced-sync reporting.
module tdm_demux4 #(
  parameter int MISS_MAX = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d,
  input  logic       sync,
  input  logic       en,
  output logic [3:0] y,
  output logic       valid,
  output logic [1:0] s,
  output logic       lock,
  output logic       err
);

  typedef enum logic {HUNT, LOCKED} state_t;

  localparam logic [2:0] MISS_LIM = 3'(MISS_MAX);

  state_t     state, state_n;
  logic [3:0] sh, sh_n, y_n;
  logic [1:0] s_n, k;
  logic [2:0] miss, miss_n, miss_inc;
  logic       valid_n, err_n, take;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      sh    <= '0;
      y     <= '0;
      s     <= '0;
      miss  <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      y     <= y_n;
      s     <= s_n;
      miss  <= miss_n;
      valid <= valid_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    sh_n     = sh;
    y_n      = y;
    s_n      = s;
    miss_n   = miss;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    take     = 1'b0;
    k        = s;
    miss_inc = miss + 3'd1;

    case (state)
      HUNT: begin
        if (en && sync) begin
          take    = 1'b1;
          k       = 2'd0;
          state_n = LOCKED;
          miss_n  = '0;
        end
      end
      LOCKED: begin
        if (en) begin
          if (sync) begin
            // A sync away from slot 0 realigns; the s=1 restart forces slots 1..2 to be rewritten.
            take   = 1'b1;
            k      = 2'd0;
            miss_n = '0;
            err_n  = (s != 2'd0);
          end else if (s != 2'd0) begin
            take = 1'b1;
            k    = s;
          end else if (miss_inc < MISS_LIM) begin
            take   = 1'b1;
            k      = 2'd0;
            miss_n = miss_inc;
          end else begin
            state_n = HUNT;
            s_n     = 2'd0;
            miss_n  = '0;
          end
        end
      end
      default: state_n = HUNT;
    endcase

    if (take) begin
      sh_n[k] = d;
      s_n     = k + 2'd1;
      if (k == 2'd3) begin
        y_n     = {d, sh[2:0]};
        valid_n = 1'b1;
      end
    end
  end

  assign lock = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - directed self-checking bench for tdm_demux4
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst, d, sync, en;
  logic [3:0] y;
  logic       valid, lock, err;
  logic [1:0] s;

  int checks = 0;
  int errors = 0;

  tdm_demux4 #(.MISS_MAX(2)) dut (
    .clk(clk), .rst(rst), .d(d), .sync(sync), .en(en),
    .y(y), .valid(valid), .s(s), .lock(lock), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step(input logic dd, input logic ss, input logic ee);
    d = dd; sync = ss; en = ee;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] fd;
    rst = 1'b1; d = 1'b0; sync = 1'b0; en = 1'b0;
    step(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    chk("rst_y", y, 4'h0);
    chk("rst_valid", valid, 0);
    chk("rst_lock", lock, 0);
    chk("rst_s", s, 0);
    chk("rst_err", err, 0);

    // frame 1,0,1,1 with sync on slot 0
    fd = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      step(fd[i], i == 0, 1'b1);
      chk("f1_lock", lock, 1);
      chk("f1_s", s, 4'((i + 1) % 4));
      chk("f1_valid", valid, (i == 3) ? 4'd1 : 4'd0);
    end
    chk("f1_y", y, 4'b1101);
    step(1'b0, 1'b0, 1'b0);
    chk("f1_valid_once", valid, 0);
    chk("f1_y_hold", y, 4'b1101);

    // back-to-back frames 0,1,1,0 then 1,1,1,1
    fd = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      step(fd[i], i == 0, 1'b1);
      chk("bb1_valid", valid, (i == 3) ? 4'd1 : 4'd0);
      chk("bb1_err", err, 0);
    end
    chk("bb1_y", y, 4'b0110);
    fd = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step(fd[i], i == 0, 1'b1);
      chk("bb2_valid", valid, (i == 3) ? 4'd1 : 4'd0);
      chk("bb2_err", err, 0);
    end
    chk("bb2_y", y, 4'b1111);

    // en toggling; sync raised on en=0 cycles must be ignored
    fd = 4'b1101;
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) step(fd[i / 2], i == 0, 1'b1);
      else            step(1'b0, 1'b1, 1'b0);
      chk("tog_s", s, 4'((i / 2 + 1) % 4));
      chk("tog_valid", valid, (i == 6) ? 4'd1 : 4'd0);
      chk("tog_err", err, 0);
    end
    chk("tog_y", y, 4'b1101);

    // misplaced sync on slot 2, then frame 0,0,0,1 from the realigned sample
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("mis_s_pre", s, 2);
    step(1'b0, 1'b1, 1'b1);
    chk("mis_err", err, 1);
    chk("mis_valid", valid, 0);
    chk("mis_s", s, 1);
    step(1'b0, 1'b0, 1'b1);
    chk("mis_err_pulse", err, 0);
    step(1'b0, 1'b0, 1'b1);
    chk("mis_valid_mid", valid, 0);
    step(1'b1, 1'b0, 1'b1);
    chk("mis_valid_end", valid, 1);
    chk("mis_y", y, 4'b1000);

    // flywheel over one missed sync, drop lock on the second
    fd = 4'b0011;
    for (int i = 0; i < 4; i++) step(fd[i], 1'b0, 1'b1);
    chk("fly_valid", valid, 1);
    chk("fly_lock", lock, 1);
    chk("fly_y", y, 4'b0011);
    step(1'b1, 1'b0, 1'b1);
    chk("drop_lock", lock, 0);
    chk("drop_s", s, 0);
    chk("drop_y", y, 4'b0011);
    chk("drop_valid", valid, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("hunt_lock", lock, 0);
      chk("hunt_s", s, 0);
      chk("hunt_valid", valid, 0);
    end
    step(1'b0, 1'b1, 1'b0);
    chk("hunt_sync_no_en", lock, 0);
    fd = 4'b1010;
    for (int i = 0; i < 4; i++) step(fd[i], i == 0, 1'b1);
    chk("relock_lock", lock, 1);
    chk("relock_valid", valid, 1);
    chk("relock_y", y, 4'b1010);

    // reset at slot 2 discards the partial frame
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    chk("mrst_y", y, 0);
    chk("mrst_valid", valid, 0);
    chk("mrst_lock", lock, 0);
    chk("mrst_s", s, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("mrst_hunt_valid", valid, 0);
      chk("mrst_hunt_lock", lock, 0);
      chk("mrst_hunt_y", y, 0);
    end
    fd = 4'b1111;
    for (int i = 0; i < 4; i++) step(fd[i], i == 0, 1'b1);
    chk("mrst_relock_valid", valid, 1);
    chk("mrst_relock_y", y, 4'b1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
